// File: rtl/run_pattern_tx_pkg.sv
// Shared types and defaults for the run-pattern transmitter.
package run_pattern_tx_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int RUN_LEN_DEF = 4;
  localparam int LEN_W       = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/run_pattern_tx_if.sv
// Frame request / serial output bundle for the run-pattern transmitter.
interface run_pattern_tx_if #(
  parameter int DATA_W = run_pattern_tx_pkg::DATA_W_DEF
);
  import run_pattern_tx_pkg::*;

  logic              start;
  logic [DATA_W-1:0] data;
  logic [LEN_W-1:0]  len;
  logic              w;
  logic              w_valid;
  logic              busy;
  logic              done;
  logic              z_exp;

  // Requester side: issues frames, watches the serial stream.
  modport master (
    output start, data, len,
    input  w, w_valid, busy, done, z_exp
  );

  // Transmitter side.
  modport slave (
    input  start, data, len,
    output w, w_valid, busy, done, z_exp
  );

endinterface

// File: rtl/run_pattern_tx_run_tracker.sv
// Tracks consecutive equal bits within a frame and flags each bit that
// completes a run of RUN_LEN. Fed with the next-cycle bit so the registered
// hit lines up with the registered serial bit.
module run_tracker
  import run_pattern_tx_pkg::*;
#(
  parameter int RUN_LEN = RUN_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_bit,
  input  logic i_valid,
  output logic o_hit
);

  localparam int CNT_W = $clog2(RUN_LEN + 1);

  logic             r_last_bit;
  logic [CNT_W-1:0] r_run_cnt;
  logic             r_hit;
  logic [CNT_W-1:0] w_run_next;

  // Next run length: a frame's first bit (clear) always restarts at 1, equal
  // bits extend the run up to RUN_LEN and hold there.
  always_comb begin
    w_run_next = r_run_cnt;
    if (i_valid) begin
      if (!i_clear && (r_run_cnt != '0) && (i_bit == r_last_bit)) begin
        w_run_next = (r_run_cnt == CNT_W'(RUN_LEN)) ? r_run_cnt : r_run_cnt + 1'b1;
      end else begin
        w_run_next = CNT_W'(1);
      end
    end else if (i_clear) begin
      w_run_next = '0;
    end
  end

  // Run state and registered hit flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_bit <= 1'b0;
      r_run_cnt  <= '0;
      r_hit      <= 1'b0;
    end else begin
      r_run_cnt <= w_run_next;
      if (i_valid) begin
        r_last_bit <= i_bit;
      end
      r_hit <= i_valid && (w_run_next == CNT_W'(RUN_LEN));
    end
  end

  assign o_hit = r_hit;

endmodule

// File: rtl/run_pattern_tx.sv
// Serialises a captured pattern word MSB first, with a done pulse per frame
// and a reference run-detector flag alongside each bit.
module run_pattern_tx
  import run_pattern_tx_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RUN_LEN = RUN_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  run_pattern_tx_if.slave  bus
);

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] w_shreg_next;
  logic [LEN_W-1:0]  r_cnt;       // bits still to send after the one on w
  logic [LEN_W-1:0]  w_cnt_next;
  logic [LEN_W-1:0]  w_len_clamped;
  logic              r_w;
  logic              r_w_valid;
  logic              r_done;
  logic              r_busy;
  logic              w_bit_next;
  logic              w_valid_next;
  logic              w_done_next;
  logic              w_frame_start;

  assign w_len_clamped = (int'(bus.len) > DATA_W) ? LEN_W'(DATA_W) : bus.len;

  // State and output registers; outputs are loaded from their next values so
  // the first bit appears the cycle right after the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_cnt     <= '0;
      r_w       <= 1'b0;
      r_w_valid <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shreg   <= w_shreg_next;
      r_cnt     <= w_cnt_next;
      r_w       <= w_bit_next;
      r_w_valid <= w_valid_next;
      r_done    <= w_done_next;
      r_busy    <= (w_state_next != IDLE);
    end
  end

  // Next-state decision.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = (bus.len == '0) ? DONE : SHIFT;
      SHIFT:   if (r_cnt == '0) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath and next output values for each state.
  always_comb begin
    w_shreg_next  = r_shreg;
    w_cnt_next    = r_cnt;
    w_bit_next    = 1'b0;
    w_valid_next  = 1'b0;
    w_done_next   = 1'b0;
    w_frame_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_frame_start = 1'b1;
          if (bus.len != '0) begin
            w_bit_next   = bus.data[DATA_W-1];
            w_valid_next = 1'b1;
            w_shreg_next = bus.data << 1;
            w_cnt_next   = w_len_clamped - LEN_W'(1);
          end else begin
            w_done_next = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (r_cnt != '0) begin
          w_bit_next   = r_shreg[DATA_W-1];
          w_valid_next = 1'b1;
          w_shreg_next = r_shreg << 1;
          w_cnt_next   = r_cnt - LEN_W'(1);
        end else begin
          w_done_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  run_tracker #(
    .RUN_LEN (RUN_LEN)
  ) u_run_tracker (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_frame_start),
    .i_bit   (w_bit_next),
    .i_valid (w_valid_next),
    .o_hit   (bus.z_exp)
  );

  assign bus.w       = r_w;
  assign bus.w_valid = r_w_valid;
  assign bus.done    = r_done;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_run_pattern_tx.sv
// Directed bench for run_pattern_tx: hand-computed per-cycle output vectors.
module tb_run_pattern_tx;

  logic clk;
  logic rst;
  int   total;
  int   passed;
  int   failed;

  run_pattern_tx_if #(.DATA_W(16)) bus ();

  run_pattern_tx #(
    .DATA_W  (16),
    .RUN_LEN (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare {w_valid, w, z_exp, busy, done} against the expected vector.
  task automatic chk(input string tag, input logic ev, input logic ew,
                     input logic ez, input logic eb, input logic ed);
    logic [4:0] obs;
    logic [4:0] exp;
    obs = {bus.w_valid, bus.w, bus.z_exp, bus.busy, bus.done};
    exp = {ev, ew, ez, eb, ed};
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed v/w/z/busy/done=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called in the cycle holding bit 0. wexp/zexp are left-aligned: bit i of
  // the frame is at position 15-i. Ends in the IDLE cycle after DONE.
  task automatic expect_frame(input string tag, input int n,
                              input logic [15:0] wexp, input logic [15:0] zexp);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_bit%0d", tag, i), 1'b1, wexp[15-i], zexp[15-i], 1'b1, 1'b0);
      step();
    end
    chk($sformatf("%s_done", tag), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk($sformatf("%s_idle", tag), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    failed = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.data  = '0;
    bus.len   = '0;
    step();
    step();
    chk("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // First start right at reset release; later data/len changes are ignored.
    rst       = 1'b0;
    bus.start = 1'b1;
    bus.data  = 16'hF000;
    bus.len   = 5'd8;
    step();
    bus.start = 1'b0;
    bus.data  = 16'h0F0F;
    bus.len   = 5'd2;
    expect_frame("f000", 8, 16'hF000, 16'h1100);

    // Alternating bits never form a run; busy spans 17 cycles.
    bus.start = 1'b1;
    bus.data  = 16'hAAAA;
    bus.len   = 5'd16;
    step();
    bus.start = 1'b0;
    expect_frame("aaaa", 16, 16'hAAAA, 16'h0000);

    // Empty frame: done in the next cycle, no valid bits.
    bus.start = 1'b1;
    bus.data  = 16'hFFFF;
    bus.len   = 5'd0;
    step();
    bus.start = 1'b0;
    chk("len0_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("len0_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // len above DATA_W clamps to 16 bits; saturated run flags bits 3..15.
    bus.start = 1'b1;
    bus.data  = 16'hFFFF;
    bus.len   = 5'd20;
    step();
    bus.start = 1'b0;
    expect_frame("clamp", 16, 16'hFFFF, 16'h1FFF);

    // Reset during bit 2 aborts the frame without a done pulse.
    bus.start = 1'b1;
    bus.data  = 16'hF000;
    bus.len   = 5'd8;
    step();
    bus.start = 1'b0;
    chk("abort_bit0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk("abort_bit1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk("abort_bit2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("abort_rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("abort_rst_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk("abort_no_done0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("abort_no_done1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // start held high: two len=4 frames, second captured after the idle cycle.
    bus.start = 1'b1;
    bus.data  = 16'h0000;
    bus.len   = 5'd4;
    step();
    bus.data  = 16'hF000;
    expect_frame("b2b_a", 4, 16'h0000, 16'h1000);
    step();
    bus.start = 1'b0;
    expect_frame("b2b_b", 4, 16'hF000, 16'h1000);

    // Two short all-ones frames: a carried-over run would flag frame 2 bit 0.
    bus.start = 1'b1;
    bus.data  = 16'hFFFF;
    bus.len   = 5'd3;
    step();
    expect_frame("carry_a", 3, 16'hE000, 16'h0000);
    step();
    bus.start = 1'b0;
    expect_frame("carry_b", 3, 16'hE000, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
